// File: rtl/gameport_pkg.sv
// Shared definitions for the game-port axis reader: FSM states, port bit
// positions and the axis count limit.
package gameport_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRIG   = 3'd1,
    SETTLE = 3'd2,
    MEAS   = 3'd3,
    DONE   = 3'd4
  } gp_state_e;

  localparam int AX_P1X  = 0;
  localparam int AX_P1Y  = 1;
  localparam int AX_P2X  = 2;
  localparam int AX_P2Y  = 3;
  localparam int BT_P1B1 = 4;
  localparam int BT_P1B2 = 5;
  localparam int BT_P2B1 = 6;
  localparam int BT_P2B2 = 7;

  localparam int         NUM_AXES = 4;
  localparam logic [7:0] AXIS_MAX = 8'd255;

endpackage

// File: rtl/gameport_tick_div.sv
// Measurement tick divider: one tick every tick_div+1 enabled cycles, with the
// division ratio captured when the divider is cleared.
module gameport_tick_div (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] tick_div,
  output logic       tick
);

  logic [7:0] div_r;
  logic [7:0] cnt_r;

  // ratio capture on clear, then 0..div_r wrap count while enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= 8'd0;
      cnt_r <= 8'd0;
    end else if (clear) begin
      div_r <= tick_div;
      cnt_r <= 8'd0;
    end else if (en) begin
      if (cnt_r == div_r) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && (cnt_r == div_r);

endmodule

// File: rtl/gameport_axis_reader.sv
// Game-port reader: fires the one-shot, times each axis bit in divided ticks
// and reports per-axis counts, timeouts and button states.
module gameport_axis_reader
  import gameport_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        poll_en,
  input  logic [15:0] poll_period,
  input  logic [7:0]  tick_div,
  input  logic [3:0]  axis_en,
  input  logic [7:0]  gp_in,
  output logic        trig,
  output logic        busy,
  output logic [31:0] axis_val,
  output logic [3:0]  axis_tmo,
  output logic [3:0]  buttons,
  output logic        valid
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [7:0]  sync_r [SYNC_STAGES];
  logic [7:0]  gs_s;
  gp_state_e   state_r, state_nx_s;
  logic [15:0] poll_cnt_r;
  logic        start_q_r;
  logic [7:0]  settle_cnt_r;
  logic        launch_s, settle_end_s, tick_s;
  logic [3:0]  done_vec_s, done_nx_vec_s, tmo_nx_vec_s;
  logic [31:0] cnt_nx_flat_s;
  logic        trig_r, busy_r, valid_r;
  logic [31:0] axis_val_r;
  logic [3:0]  axis_tmo_r, buttons_r;

  // input synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= 8'd0;
    end else begin
      sync_r[0] <= gp_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  assign gs_s = sync_r[SYNC_STAGES-1];

  // start is taken on its rising edge so a held request launches only once;
  // the +1 makes trig-to-trig spacing equal poll_period
  assign launch_s = (start & ~start_q_r) |
                    (poll_en & (({1'b0, poll_cnt_r} + 17'd1) >= {1'b0, poll_period}));
  assign settle_end_s = (state_r == SETTLE) && (settle_cnt_r == SETTLE_LAST);

  // poll interval counter, start edge history and settle timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      poll_cnt_r   <= 16'd0;
      start_q_r    <= 1'b0;
      settle_cnt_r <= 8'd0;
    end else begin
      start_q_r <= start;
      if (state_nx_s == TRIG) begin
        poll_cnt_r <= 16'd0;
      end else if (poll_cnt_r != 16'hFFFF) begin
        poll_cnt_r <= poll_cnt_r + 16'd1;
      end else begin
        poll_cnt_r <= poll_cnt_r;
      end
      if (state_r == SETTLE) begin
        settle_cnt_r <= settle_cnt_r + 8'd1;
      end else begin
        settle_cnt_r <= 8'd0;
      end
    end
  end

  gameport_tick_div u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (settle_end_s),
    .en       (state_r == MEAS),
    .tick_div (tick_div),
    .tick     (tick_s)
  );

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    logic [7:0] cnt_r, cnt_nx_s;
    logic       done_r, done_nx_s, tmo_r, tmo_nx_s;

    // per-axis tick counting; a low sample or the count limit ends the axis
    always_comb begin
      cnt_nx_s  = cnt_r;
      done_nx_s = done_r;
      tmo_nx_s  = tmo_r;
      if (tick_s && !done_r) begin
        if (gs_s[i]) begin
          cnt_nx_s = cnt_r + 8'd1;
          if (cnt_r == AXIS_MAX - 8'd1) begin
            done_nx_s = 1'b1;
            tmo_nx_s  = 1'b1;
          end else begin
            done_nx_s = 1'b0;
          end
        end else begin
          done_nx_s = 1'b1;
        end
      end else begin
        cnt_nx_s = cnt_r;
      end
    end

    // disabled axes start out done, so they finish at 0 with no timeout
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_r  <= 8'd0;
        done_r <= 1'b0;
        tmo_r  <= 1'b0;
      end else if (state_r == TRIG) begin
        cnt_r  <= 8'd0;
        done_r <= ~axis_en[i];
        tmo_r  <= 1'b0;
      end else begin
        cnt_r  <= cnt_nx_s;
        done_r <= done_nx_s;
        tmo_r  <= tmo_nx_s;
      end
    end

    assign done_vec_s[i]           = done_r;
    assign done_nx_vec_s[i]        = done_nx_s;
    assign tmo_nx_vec_s[i]         = tmo_nx_s;
    assign cnt_nx_flat_s[8*i +: 8] = cnt_nx_s;
  end

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nx_s = TRIG;
        else          state_nx_s = IDLE;
      end
      TRIG: state_nx_s = SETTLE;
      SETTLE: begin
        if (settle_end_s) begin
          if (&done_vec_s) state_nx_s = DONE;
          else             state_nx_s = MEAS;
        end else begin
          state_nx_s = SETTLE;
        end
      end
      MEAS: begin
        if (tick_s && (&done_nx_vec_s)) state_nx_s = DONE;
        else                            state_nx_s = MEAS;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // state register and registered outputs, results captured entering DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      trig_r     <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      axis_val_r <= 32'd0;
      axis_tmo_r <= 4'd0;
      buttons_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      trig_r  <= (state_nx_s == TRIG);
      busy_r  <= (state_nx_s != IDLE);
      valid_r <= (state_nx_s == DONE);
      if (state_nx_s == DONE) begin
        axis_val_r <= cnt_nx_flat_s;
        axis_tmo_r <= tmo_nx_vec_s;
        buttons_r  <= ~gs_s[BT_P2B2:BT_P1B1];
      end else begin
        axis_val_r <= axis_val_r;
        axis_tmo_r <= axis_tmo_r;
        buttons_r  <= buttons_r;
      end
    end
  end

  assign trig     = trig_r;
  assign busy     = busy_r;
  assign valid    = valid_r;
  assign axis_val = axis_val_r;
  assign axis_tmo = axis_tmo_r;
  assign buttons  = buttons_r;

endmodule

// File: tb/tb_gameport_axis_reader.sv
// Bench for gameport_axis_reader: one-shot emulator on gp_in, cycle-level
// behavioural model of launches, results and timing, directed plus random runs.
module tb_gameport_axis_reader;
  localparam int SYNC   = 2;
  localparam int SETTLE = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, poll_en = 1'b0;
  logic [15:0] poll_period = 16'd0;
  logic [7:0]  tick_div = 8'd0;
  logic [3:0]  axis_en = 4'd0;
  logic [7:0]  gp_in = 8'hF0;
  logic        trig, busy, valid;
  logic [31:0] axis_val;
  logic [3:0]  axis_tmo, buttons;

  int checks = 0, errors = 0;
  int cyc = 0;
  int hcfg [4];
  int rem  [4];
  logic [3:0] btn_n = 4'hF;

  gameport_axis_reader #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .poll_en(poll_en),
    .poll_period(poll_period), .tick_div(tick_div), .axis_en(axis_en),
    .gp_in(gp_in), .trig(trig), .busy(busy), .axis_val(axis_val),
    .axis_tmo(axis_tmo), .buttons(buttons), .valid(valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + one-shot emulator ----------------
  bit          pend = 0, exp_trig = 0, start_prev = 0, was_rst = 1;
  bit          busy_e, valid_e;
  int          done_cyc = -1, t_prev = 0, d_m, n_last, h, c, nt;
  logic [31:0] last_val = '0, nxt_val;
  logic [3:0]  last_tmo = '0, last_btn = '0, nxt_tmo, nxt_btn, ax;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0; exp_trig = 0; start_prev = 0; was_rst = 1;
      last_val = '0; last_tmo = '0; last_btn = '0;
      for (int i = 0; i < 4; i++) rem[i] = 0;
      gp_in = {btn_n, 4'b0000};
    end else begin
      if (was_rst) begin t_prev = cyc; was_rst = 0; end
      chk("trig", trig, exp_trig);
      if (exp_trig) begin
        pend = 1; t_prev = cyc;
        d_m = int'(tick_div); n_last = 0; nxt_val = '0; nxt_tmo = '0;
        for (int i = 0; i < 4; i++) if (axis_en[i]) begin
          h = hcfg[i];
          if (h == 0 || h - 1 + SYNC - SETTLE < 0) c = 0;
          else c = (h - 1 + SYNC - SETTLE) / (d_m + 1);
          if (c >= 255) begin nxt_val[8*i +: 8] = 8'd255; nxt_tmo[i] = 1'b1; nt = 255; end
          else begin nxt_val[8*i +: 8] = 8'(c); nt = c + 1; end
          if (nt > n_last) n_last = nt;
        end
        nxt_btn  = ~btn_n;
        done_cyc = cyc + SETTLE + n_last * (d_m + 1) + 1;
      end
      busy_e  = pend && (cyc <= done_cyc);
      valid_e = pend && (cyc == done_cyc);
      chk("busy", busy, busy_e);
      chk("valid", valid, valid_e);
      if (valid_e) begin last_val = nxt_val; last_tmo = nxt_tmo; last_btn = nxt_btn; end
      chk("axis_val", axis_val, last_val);
      chk("axis_tmo", axis_tmo, last_tmo);
      chk("buttons", buttons, last_btn);
      exp_trig = !busy_e && ((start && !start_prev) ||
                 (poll_en && (cyc + 1 - t_prev) >= int'(poll_period)));
      start_prev = start;
      for (int i = 0; i < 4; i++) begin
        if (trig) rem[i] = hcfg[i];
        ax[i] = (rem[i] > 0);
        if (rem[i] > 0) rem[i]--;
      end
      gp_in = {btn_n, ax};
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    bit ok = 0;
    for (int k = 0; k < maxc && !ok; k++) begin @(posedge clk); #1; if (valid) ok = 1; end
    if (!ok) begin checks++; errors++; $display("FAIL wait_valid: none within %0d cycles", maxc); end
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    for (int k = 0; k < maxc && busy; k++) step(1);
    if (busy) begin checks++; errors++; $display("FAIL wait_idle: busy after %0d cycles", maxc); end
  endtask

  task automatic set_h(input int a, input int b, input int c2, input int d2);
    hcfg[0] = a; hcfg[1] = b; hcfg[2] = c2; hcfg[3] = d2;
  endtask

  int n0, lat, tcount;
  int tt [4];

  initial begin
    set_h(0, 0, 0, 0);
    repeat (3) @(posedge clk); #2; reset = 1'b0;
    chk("rst_trig", trig, 0); chk("rst_busy", busy, 0); chk("rst_valid", valid, 0);
    chk("rst_val", axis_val, 0); chk("rst_tmo", axis_tmo, 0); chk("rst_btn", buttons, 0);
    step(3);

    // long single-axis measurement, 186-cycle ticks
    set_h(128 * 186, 0, 0, 0); tick_div = 8'd185; axis_en = 4'b0001;
    pulse_start(); wait_valid(30000);
    chk("t1_p1x_128pm1", (axis_val[7:0] >= 8'd127 && axis_val[7:0] <= 8'd129), 1);
    chk("t1_tmo", axis_tmo, 4'b0000);
    wait_idle(100);

    // four axes: 10, 0, timeout, 64 ticks
    set_h(43, 0, 2000, 259); tick_div = 8'd3; axis_en = 4'hF; btn_n = 4'b0101;
    step(3); pulse_start(); wait_valid(3000);
    chk("t2_vals", axis_val, 32'h40FF000A);
    chk("t2_tmo", axis_tmo, 4'b0100);
    chk("t2_btn", buttons, 4'b1010);
    wait_idle(100);

    // all axes disabled: shortest latency, buttons inverted
    btn_n = 4'b1010; axis_en = 4'b0000; step(3);
    n0 = cyc; start = 1'b1; step(1); start = 1'b0;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin @(posedge clk); #1; if (valid) lat = cyc - n0; end
    #1;
    chk("t3_latency", lat, 1 + SETTLE + 1);
    chk("t3_btn", buttons, 4'b0101);
    chk("t3_vals", axis_val, 32'd0);
    wait_idle(100);

    // periodic polling with start held high
    set_h(20, 20, 20, 20); tick_div = 8'd0; axis_en = 4'hF;
    poll_period = 16'd5000; poll_en = 1'b1; start = 1'b1;
    tcount = 0;
    for (int k = 0; k < 17000 && tcount < 4; k++) begin
      @(posedge clk); #1;
      if (trig) begin tt[tcount] = cyc; tcount++; end
      #1;
    end
    chk("t4_trig_count", tcount, 4);
    for (int i = 1; i < 4; i++) chk("t4_spacing", tt[i] - tt[i-1], 5000);
    poll_en = 1'b0; start = 1'b0; step(2); wait_idle(200);

    // back-to-back polling
    set_h(9, 0, 30, 0); tick_div = 8'd1; poll_period = 16'd0; poll_en = 1'b1;
    step(80); poll_en = 1'b0; step(2); wait_idle(200);

    // tick_div change mid-measurement, then next measurement with 1-cycle ticks
    set_h(83, 0, 0, 0); tick_div = 8'd3; axis_en = 4'b0001; step(2);
    pulse_start(); step(12); tick_div = 8'd0;
    wait_valid(500);
    chk("t6_keep_div", axis_val[7:0], 8'd20);
    wait_idle(50);
    set_h(23, 0, 0, 0); step(2); pulse_start(); wait_valid(500);
    chk("t6_new_div", axis_val[7:0], 8'd20);
    wait_idle(50);

    // asynchronous reset mid-measurement
    set_h(2000, 2000, 2000, 2000); tick_div = 8'd3; axis_en = 4'hF; step(2);
    pulse_start(); step(40); #1; reset = 1'b1; #1;
    chk("t7_trig", trig, 0); chk("t7_busy", busy, 0); chk("t7_valid", valid, 0);
    chk("t7_val", axis_val, 0); chk("t7_tmo", axis_tmo, 0); chk("t7_btn", buttons, 0);
    repeat (3) @(posedge clk); #2; reset = 1'b0;
    set_h(43, 0, 0, 0); axis_en = 4'b0001; step(5);
    pulse_start(); wait_valid(500);
    chk("t7_after", axis_val[7:0], 8'd10);
    wait_idle(50);

    // randomized measurements, some with ignored mid-run start pulses
    for (int it = 0; it < 20; it++) begin
      axis_en = 4'($urandom_range(0, 15)); tick_div = 8'($urandom_range(0, 3));
      btn_n = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) hcfg[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1100);
      step(3); pulse_start();
      if (it % 2 == 1) begin step($urandom_range(3, 40)); pulse_start(); end
      step(2); wait_idle(4000);
    end

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
